// File: rtl/quiz_disp_pkg.sv
// rtl/quiz_disp_pkg.sv - shared segment patterns and scan-state types for the digit display
package quiz_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // {g,f,e,d,c,b,a}, active-low; element k is the pattern for digit k
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        IDX_ONES = 1'b0,
        IDX_TENS = 1'b1
    } digit_idx_e;

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit code to active-low 7-segment pattern
module seg7_decode
    import quiz_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        for (int k = 0; k < 10; k++) begin
            if (code == 4'(k)) begin
                seg = SEG_TABLE[k];
            end
        end
    end

endmodule

// File: rtl/digit_display_scan.sv
// rtl/digit_display_scan.sv - two-digit multiplexed 7-segment scanner with frame-aligned digit updates
module digit_display_scan
    import quiz_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    input  logic       en,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] r_cnt;
    digit_idx_e    r_idx;
    logic [3:0]    r_shadow_tens;
    logic [3:0]    r_shadow_ones;
    logic          r_pending;
    logic [3:0]    r_disp_tens;
    logic [3:0]    r_disp_ones;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_frame_start;

    logic          w_wrap;
    logic          w_boundary;
    phase_e        w_phase;
    logic [3:0]    w_code;
    logic [6:0]    w_dec;
    logic          w_tens_dark;
    logic [6:0]    w_seg_nxt;
    logic [1:0]    w_an_nxt;

    assign w_wrap     = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_boundary = w_wrap && (r_idx == IDX_TENS);
    assign w_phase    = (int'(r_cnt) < GUARD_CYC) ? PH_GUARD : PH_DRIVE;
    assign w_code     = (r_idx == IDX_TENS) ? r_disp_tens : r_disp_ones;

    seg7_decode u_dec (
        .code (w_code),
        .seg  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= IDX_ONES;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_TENS) ? IDX_ONES : IDX_TENS;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Digits only move at the frame boundary; a load landing on the boundary bypasses the shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_tens <= '0;
            r_shadow_ones <= '0;
            r_pending     <= 1'b0;
            r_disp_tens   <= '0;
            r_disp_ones   <= '0;
        end else begin
            if (load) begin
                r_shadow_tens <= tens;
                r_shadow_ones <= ones;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp_tens <= tens;
                    r_disp_ones <= ones;
                end else if (r_pending) begin
                    r_disp_tens <= r_shadow_tens;
                    r_disp_ones <= r_shadow_ones;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_an_nxt    = 2'b11;
        w_seg_nxt   = SEG_BLANK;
        w_tens_dark = (r_idx == IDX_TENS) && blank_lz && (r_disp_tens == 4'd0);
        if (en && (w_phase == PH_DRIVE) && !w_tens_dark) begin
            w_an_nxt  = (r_idx == IDX_TENS) ? 2'b01 : 2'b10;
            w_seg_nxt = w_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg         <= SEG_BLANK;
            r_an          <= 2'b11;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt;
            r_an          <= w_an_nxt;
            r_frame_start <= w_boundary;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_digit_display_scan.sv
// tb/tb_digit_display_scan.sv - directed table-driven bench for digit_display_scan
module tb_digit_display_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       load;
    logic       en;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_start;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    always #5 clk = ~clk;

    digit_display_scan #(.REFRESH_DIV(8), .GUARD_CYC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tens        (tens),
        .ones        (ones),
        .load        (load),
        .en          (en),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       blz;
        int         pos;
        logic [6:0] so;
        logic [1:0] tan;
        logic [6:0] ts;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        edges++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs one 16-cycle frame from its first cycle, checking every visible position.
    task automatic check_frame(input string nm,
                               input int pa, input logic [3:0] ta, input logic [3:0] oa,
                               input int pb, input logic [3:0] tb2, input logic [3:0] ob,
                               input logic [6:0] so, input logic [1:0] tan, input logic [6:0] ts);
        logic [1:0] ea;
        logic [6:0] es;
        for (int i = 0; i < 16; i++) begin
            load = 1'b0;
            if (i == pa) begin
                tens = ta; ones = oa; load = 1'b1;
            end else if (i == pb) begin
                tens = tb2; ones = ob; load = 1'b1;
            end
            tick();
            load = 1'b0;
            if ((i % 8) < 2) begin
                ea = 2'b11; es = 7'b1111111;
            end else if (i < 8) begin
                ea = 2'b10; es = so;
            end else begin
                ea = tan; es = (tan == 2'b11) ? 7'b1111111 : ts;
            end
            chk($sformatf("%s an pos%0d", nm, i), 32'(an), 32'(ea));
            chk($sformatf("%s seg pos%0d", nm, i), 32'(seg), 32'(es));
            chk($sformatf("%s fs pos%0d", nm, i), 32'(frame_start), 32'(i == 15));
            if (i == pa || i == pb)
                chk($sformatf("%s pending after load pos%0d", nm, i), 32'(dut.r_pending), 32'(i != 15));
        end
        if (pa >= 0 || pb >= 0)
            chk({nm, " pending at frame end"}, 32'(dut.r_pending), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] p_so;
        logic [1:0] p_tan;
        logic [6:0] p_ts;

        vecs[0] = '{t: 4'd1,  o: 4'd7,  blz: 1'b0, pos: 3,  so: 7'b1111000, tan: 2'b01, ts: 7'b1111001};
        vecs[1] = '{t: 4'd0,  o: 4'd5,  blz: 1'b1, pos: 9,  so: 7'b0010010, tan: 2'b11, ts: 7'b1111111};
        vecs[2] = '{t: 4'd12, o: 4'd15, blz: 1'b1, pos: 5,  so: 7'b0111111, tan: 2'b01, ts: 7'b0111111};
        vecs[3] = '{t: 4'd4,  o: 4'd8,  blz: 1'b0, pos: 15, so: 7'b0000000, tan: 2'b01, ts: 7'b0011001};
        vecs[4] = '{t: 4'd2,  o: 4'd6,  blz: 1'b0, pos: 0,  so: 7'b0000010, tan: 2'b01, ts: 7'b0100100};

        rst_n = 1'b0; tens = '0; ones = '0; load = 1'b0; en = 1'b1; blank_lz = 1'b0;
        tick();
        tick();
        chk("reset an", 32'(an), 32'h3);
        chk("reset seg", 32'(seg), 32'h7f);
        chk("reset fs", 32'(frame_start), 32'd0);
        chk("reset pending", 32'(dut.r_pending), 32'd0);
        rst_n = 1'b1;
        edges = 0;

        p_so = 7'b1000000; p_tan = 2'b01; p_ts = 7'b1000000;
        foreach (vecs[k]) begin
            check_frame($sformatf("v%0d load", k), vecs[k].pos, vecs[k].t, vecs[k].o,
                        -1, 4'd0, 4'd0, p_so, p_tan, p_ts);
            blank_lz = vecs[k].blz;
            check_frame($sformatf("v%0d show", k), -1, 4'd0, 4'd0, -1, 4'd0, 4'd0,
                        vecs[k].so, vecs[k].tan, vecs[k].ts);
            p_so = vecs[k].so; p_tan = vecs[k].tan; p_ts = vecs[k].ts;
        end

        // Two loads in one frame: only the later one may ever be shown.
        check_frame("dbl load", 2, 4'd3, 4'd4, 10, 4'd9, 4'd5, p_so, p_tan, p_ts);
        check_frame("dbl show", -1, 4'd0, 4'd0, -1, 4'd0, 4'd0, 7'b0010010, 2'b01, 7'b0010000);

        // Dark display keeps scanning; then reset lands mid-DRIVE with a load pending.
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            load = 1'b0;
            if (j == 17) begin
                tens = 4'd7; ones = 4'd7; load = 1'b1;
            end
            tick();
            load = 1'b0;
            chk($sformatf("dark an c%0d", j), 32'(an), 32'h3);
            chk($sformatf("dark seg c%0d", j), 32'(seg), 32'h7f);
            chk($sformatf("dark fs c%0d", j), 32'(frame_start), 32'((edges - 1) % 16 == 15));
        end
        chk("dark pending set", 32'(dut.r_pending), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst an", 32'(an), 32'h3);
        chk("midrst seg", 32'(seg), 32'h7f);
        chk("midrst fs", 32'(frame_start), 32'd0);
        chk("midrst pending", 32'(dut.r_pending), 32'd0);
        chk("midrst cnt", 32'(dut.r_cnt), 32'd0);
        chk("midrst idx", 32'(dut.r_idx), 32'd0);
        rst_n = 1'b1;
        en = 1'b1;
        blank_lz = 1'b0;
        edges = 0;
        check_frame("post rst", -1, 4'd0, 4'd0, -1, 4'd0, 4'd0, 7'b1000000, 2'b01, 7'b1000000);
        check_frame("post rst2", -1, 4'd0, 4'd0, -1, 4'd0, 4'd0, 7'b1000000, 2'b01, 7'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_display_scan.md
DIGIT_DISPLAY_SCAN -- requirements
Module: digit_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter GUARD_CYC, default 1000, anode-off cycles at start of each slot; legal range 0 to REFRESH_DIV-1.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tens  input  4  tens digit code from the digit splitter.
REQ-006 ones  input  4  ones digit code from the digit splitter.
REQ-007 load  input  1  one-cycle strobe; tens/ones sampled when high.
REQ-008 en  input  1  display enable; 0 forces display dark.
REQ-009 blank_lz  input  1  1 = suppress leading zero in tens position.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 an  output  2  digit anodes {tens,ones}, active-low.
REQ-012 frame_start  output  1  one-cycle pulse on each frame boundary.

Function
REQ-013 Slot counter cnt runs 0..REFRESH_DIV-1 and wraps; index idx (0=ones, 1=tens) toggles on each wrap.
REQ-014 Frame boundary = the cycle in which cnt wraps while idx=1; frame_start SHALL be high for that cycle only.
REQ-015 A load SHALL copy tens/ones into a shadow register and set a pending flag; a later load before the boundary overwrites the shadow.
REQ-016 At a frame boundary with pending set, the displayed digits SHALL take the shadow value and pending SHALL clear.
REQ-017 A load in the boundary cycle itself SHALL be applied at that boundary, with pending left clear.
REQ-018 Displayed digits SHALL never change except at a frame boundary, so no frame mixes old and new digits.
REQ-019 Each slot has two phases: GUARD while cnt < GUARD_CYC, then DRIVE for the rest of the slot.
REQ-020 In GUARD, an = 2'b11 and seg = 7'b1111111.
REQ-021 In DRIVE, an drives low only the bit for idx, and seg carries the decoded digit.
REQ-022 Decode: codes 0-9 SHALL give the standard active-low patterns (0=1000000, 1=1111001, 7=1111000, 8=0000000).
REQ-023 Decode: codes 10-15 SHALL give a dash, 0111111.
REQ-024 When blank_lz=1 and the displayed tens digit is 0, the tens slot SHALL keep an=2'b11 for the whole slot.
REQ-025 en=0 SHALL force an=2'b11 and seg=7'b1111111 while cnt, idx, shadow and pending keep operating.
REQ-026 seg, an and frame_start SHALL be registered, each lagging the driving cnt/idx state by exactly one cycle.
REQ-027 Output changes SHALL be glitch-free: no combinational path from inputs to outputs.

Reset
REQ-028 While rst_n=0 at a rising edge, the block SHALL set cnt=0, idx=0, shadow=0, displayed digits=0, pending=0, an=2'b11, seg=7'b1111111 and frame_start=0.
REQ-029 A reset asserted mid-slot or mid-frame SHALL discard the pending value.
REQ-030 After reset release, scanning SHALL restart from the GUARD phase of the ones slot.

Structure
REQ-031 Shared package quiz_disp_pkg SHALL hold SEG_BLANK, SEG_DASH, the 0-9 segment table and the digit-index encoding.
REQ-032 Sub-module seg7_decode SHALL be the single combinational 4-bit to 7-segment decoder, instantiated once and muxed by idx.
REQ-033 The phase state (GUARD/DRIVE) SHALL be an enumerated type defined in quiz_disp_pkg.

Verification (REFRESH_DIV=8, GUARD_CYC=2 for all scenarios)
REQ-034 Reset then load tens=1, ones=7 in frame 0 -> frame 0 shows 0/0; from the next frame boundary the ones slot shows 1111000 and the tens slot shows 1111001.
REQ-035 Steady display, check one slot -> an=11 for 2 cycles, then an=10 (ones slot) or 01 (tens slot) for 6 cycles; frame_start period is 16 cycles.
REQ-036 Two loads in one frame (3/4, then 9/5) -> only 9/5 appears at the boundary; 3/4 is never displayed.
REQ-037 Load coincident with the boundary cycle -> the new digits are shown in the frame that starts immediately, and pending reads 0 afterwards.
REQ-038 blank_lz=1 with tens=0, ones=5 -> the tens slot has an=11 throughout; tens=12, ones=15 -> both slots show 0111111.
REQ-039 en=0 for 20 cycles, then reset asserted mid-DRIVE -> the display stays dark with frame_start still pulsing; after reset all REQ-028 values hold and pending is cleared.
